vga_frame_buffer: RTL
=====================

VGA_FRAME_BUFFER -- requirements
Module: vga_frame_buffer

Interface
REQ-001 Parameter FB_W, default 160, frame buffer width in cells.
REQ-002 Parameter FB_H, default 120, frame buffer height in cells.
REQ-003 Parameter SCREEN_X, default 640, visible horizontal pixels.
REQ-004 Parameter SCREEN_Y, default 480, visible vertical pixels.
REQ-005 clk  input  1  pixel clock (25 MHz); all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 posX  input  10  horizontal position from the VGA driver.
REQ-008 posY  input  9  vertical position from the VGA driver.
REQ-009 pixel_out  output  3  RGB colour to the driver pixelIn.
REQ-010 wr_valid  input  1  write request valid.
REQ-011 wr_ready  output  1  write request accepted when high with wr_valid.
REQ-012 wr_x  input  8  write cell column.
REQ-013 wr_y  input  7  write cell row.
REQ-014 wr_color  input  3  write cell colour.
REQ-015 clr_start  input  1  single-cycle request to fill the buffer.
REQ-016 clr_color  input  3  fill colour, sampled with clr_start.
REQ-017 busy  output  1  high while a fill is in progress.

Function
REQ-018 Storage SHALL be FB_W*FB_H = 19200 cells of 3 bits: one synchronous read port and one write port.
REQ-019 Cell address SHALL be y*FB_W + x, 15 bits, computed as (y<<7)+(y<<5)+x for the defaults.
REQ-020 Each cell SHALL map to a 4x4 screen block: read cell = (posX>>2, posY>>2).
REQ-021 pixel_out SHALL be registered with 1-cycle latency from posX/posY.
REQ-022 pixel_out SHALL be 3'b000 in the cycle after posX>=SCREEN_X or posY>=SCREEN_Y; memory contents SHALL NOT be used for that cycle.
REQ-023 FSM states SHALL be IDLE and FILL.
REQ-024 IDLE->FILL on clr_start=1: latch clr_color, clear the fill counter to 0, set busy=1.
REQ-025 In FILL, one cell per cycle SHALL be written with the latched colour at the fill counter address, incrementing the counter.
REQ-026 FILL->IDLE in the cycle after address 19199 is written; busy=0 from that edge; the fill takes exactly 19200 cycles.
REQ-027 clr_start during FILL SHALL be ignored; the fill is not restarted and the colour is not changed.
REQ-028 wr_ready SHALL be combinational: 1 only in IDLE with clr_start=0.
REQ-029 A write handshake (wr_valid & wr_ready) SHALL commit wr_color to cell (wr_x, wr_y) at that edge.
REQ-030 Writes with wr_x>=FB_W or wr_y>=FB_H SHALL complete the handshake and be discarded without modifying memory.
REQ-031 clr_start and wr_valid in the same IDLE cycle: the fill SHALL win and the write SHALL NOT be accepted.
REQ-032 A read and a write to the same cell in the same cycle SHALL return the old data; the new data SHALL be visible from the next read.
REQ-033 Video reads SHALL never stall and SHALL be independent of FSM state.

Reset
REQ-034 On rst: state=FILL, fill colour=3'b000, fill counter=0, busy=1, pixel_out=3'b000, wr_ready=0.
REQ-035 The power-up fill SHALL clear all 19200 cells to 0 before the first write is accepted.
REQ-036 rst asserted mid-fill or mid-write SHALL restart the black fill from address 0; a write in progress is dropped.

Verification
REQ-037 rst for 1 cycle, then idle -> busy=1 for exactly 19200 cycles; wr_ready=0 throughout; all cells read 0.
REQ-038 Write (10,5,3'b101), then posX=40..43, posY=20..23 -> pixel_out=3'b101 one cycle later; posX=44 -> 0.
REQ-039 Write (200,5,3'b111) -> handshake completes in 1 cycle; cell (40,5) is unchanged.
REQ-040 clr_start with clr_color=3'b010 and wr_valid in the same cycle -> write refused, fill of 010 runs; clr_start at cycle 100 of the fill is ignored; busy drops after 19200 cycles.
REQ-041 posX=640 or posY=480 with a non-zero cell under the address -> pixel_out=0.
REQ-042 rst at fill cycle 5000 -> counter restarts at 0; busy stays high for 19200 further cycles; colour=000.

Source files
------------

// File: rtl/vga_frame_buffer.sv
// VGA frame buffer: a FB_W x FB_H grid of 3-bit colour cells, each shown as a
// 4x4 block of screen pixels. A host write port and a whole-buffer fill engine
// share one memory write port. The video read port never stalls. Reset starts
// a black fill, so the buffer is clean before the first host write is taken.
module vga_frame_buffer #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCREEN_X = 640,
    parameter int SCREEN_Y = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] posX,
    input  logic [8:0] posY,
    output logic [2:0] pixel_out,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_x,
    input  logic [6:0] wr_y,
    input  logic [2:0] wr_color,
    input  logic       clr_start,
    input  logic [2:0] clr_color,
    output logic       busy
);

    localparam int CELLS  = FB_W * FB_H;
    localparam int ADDR_W = $clog2(CELLS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } FillState;

    FillState          state, nextState;
    logic [ADDR_W-1:0] fillCount, fillCountNext;
    logic [2:0]        fillColor, fillColorNext;

    logic [2:0]        mem [CELLS];

    logic              wrInRange;
    logic [ADDR_W-1:0] hostAddr;
    logic              memWe;
    logic [ADDR_W-1:0] memWAddr;
    logic [2:0]        memWData;

    logic [7:0]        rdCellX;
    logic [6:0]        rdCellY;
    logic              rdVisible;
    logic [ADDR_W-1:0] rdAddr;

    // Fill engine registers; reset lands in FILL with black at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            fillCount <= '0;
            fillColor <= 3'b000;
        end else begin
            state     <= nextState;
            fillCount <= fillCountNext;
            fillColor <= fillColorNext;
        end
    end

    // Next state and handshake. A fill request beats a host write in the same cycle.
    always_comb begin
        nextState     = state;
        fillCountNext = fillCount;
        fillColorNext = fillColor;
        busy          = 1'b0;
        wr_ready      = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = !clr_start;
                if (clr_start) begin
                    nextState     = FILL;
                    fillCountNext = '0;
                    fillColorNext = clr_color;
                end
            end
            FILL: begin
                busy          = 1'b1;
                fillCountNext = fillCount + 1'b1;
                if (fillCount == LAST_ADDR) begin
                    nextState     = IDLE;
                    fillCountNext = '0;
                end
            end
        endcase
    end

    // Decode the host write address and reject cells outside the grid.
    always_comb begin
        wrInRange = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
        hostAddr  = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);
    end

    // Choose the single memory write: fill engine first, then an accepted host write.
    always_comb begin
        memWe    = 1'b0;
        memWAddr = fillCount;
        memWData = fillColor;
        if (!rst) begin
            if (state == FILL) begin
                memWe = 1'b1;
            end else if (wr_valid && wr_ready && wrInRange) begin
                memWe    = 1'b1;
                memWAddr = hostAddr;
                memWData = wr_color;
            end
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memWAddr] <= memWData;
        end
    end

    // Map the screen position to a cell; anything off the visible area is blanked.
    always_comb begin
        rdCellX   = posX[9:2];
        rdCellY   = posY[8:2];
        rdVisible = (32'(posX) < SCREEN_X) && (32'(posY) < SCREEN_Y) &&
                    (32'(rdCellX) < FB_W) && (32'(rdCellY) < FB_H);
        rdAddr    = rdVisible ? (ADDR_W'(rdCellY) * ADDR_W'(FB_W) + ADDR_W'(rdCellX)) : '0;
    end

    // Registered video read; a same-cycle write to the cell shows up one read later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out <= 3'b000;
        end else if (rdVisible) begin
            pixel_out <= mem[rdAddr];
        end else begin
            pixel_out <= 3'b000;
        end
    end

endmodule
